stream_fifo: RTL
================

STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries; any integer >= 2, power of two not required.
REQ-002 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-003 SHALL have parameter AF_LEVEL, default 14, almost_full threshold in entries, 1..DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold in entries, 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port flush, input, 1, synchronous clear of contents.
REQ-009 SHALL have port wr_en, input, 1, write request.
REQ-010 SHALL have port din, input, WIDTH, write data.
REQ-011 SHALL have port rd_en, input, 1, read request.
REQ-012 SHALL have port dout, output, WIDTH, read data.
REQ-013 SHALL have port dout_valid, output, 1, dout carries valid data.
REQ-014 SHALL have ports full, empty, almost_full, almost_empty, each output, 1, status flags.
REQ-015 SHALL have port count, output, $clog2(DEPTH+1), current occupancy.
REQ-016 SHALL have port overflow, output, 1, sticky: write rejected since last clear.
REQ-017 SHALL have port underflow, output, 1, sticky: read rejected since last clear.
REQ-018 SHALL have port clr_err, input, 1, synchronous clear of overflow and underflow.

Function
REQ-019 SHALL accept a write when wr_en=1 and (full=0 or a read is accepted in the same cycle).
REQ-020 SHALL accept a read when rd_en=1 and empty=0; reads at empty are rejected, even when a write is accepted in the same cycle.
REQ-021 SHALL update count by +1 on write only, -1 on read only, and 0 when both are accepted; no lost updates.
REQ-022 SHALL wrap the write and read pointers from DEPTH-1 to 0, independent of DEPTH being a power of two.
REQ-023 SHALL drive full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL); all decoded from registered count, no input paths.
REQ-024 FWFT=0: SHALL register mem[rd_ptr] into dout on the accepted-read edge, pulse dout_valid high for exactly the following cycle, and hold dout at its last value otherwise (no zeroing).
REQ-025 FWFT=1: SHALL present the head entry on dout whenever empty=0, with dout_valid = !empty; an accepted read advances to the next entry on the next edge.
REQ-026 SHALL set overflow on wr_en=1 when the write is rejected, and underflow on rd_en=1 when the read is rejected; both hold until clr_err, flush or reset.
REQ-027 flush=1 SHALL, on the next edge, zero both pointers and count, deassert dout_valid, clear overflow and underflow, and ignore wr_en/rd_en in that cycle; memory contents are not cleared.
REQ-028 clr_err SHALL take priority over a same-cycle set of overflow or underflow.
REQ-029 Memory storage SHALL have no reset; data is written only on accepted writes.

Reset
REQ-030 On rstn=0, asynchronously: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, dout=0, dout_valid=0, overflow=0, underflow=0.
REQ-031 Reset asserted mid-transfer SHALL discard all pending entries; the first accepted write after release SHALL be the first data read.

Verification
REQ-032 Fill/drain (FWFT=0, DEPTH=16): write 0x00..0x0F -> full=1 and count=16 after the 16th edge; 16 reads -> dout 0x00..0x0F in order, each one cycle after its read, then empty=1.
REQ-033 Full plus simultaneous read/write: at count=16, wr_en=rd_en=1 with din=0xAA -> count stays 16, overflow stays 0, 0xAA is read out last.
REQ-034 Empty plus simultaneous read/write: at count=0, wr_en=rd_en=1 with din=0x55 -> count=1, underflow=1, next read returns 0x55; clr_err=1 -> underflow=0.
REQ-035 Non-power-of-two wrap (DEPTH=5, FWFT=1): 12 interleaved write/read pairs -> dout always equals the oldest unread value, with no corruption across the wrap.
REQ-036 Thresholds: count 13->14 sets almost_full; count 3->2 sets almost_empty; an extra write at count=16 -> overflow=1 and count unchanged.
REQ-037 Flush/reset mid-operation: with count=7, flush=1 together with wr_en=1 -> next cycle count=0, empty=1, write dropped; repeat with rstn=0 asserted between edges -> outputs reach reset values with no clock edge.

Source files
------------

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
//   Single-clock synchronous FIFO with a parameterizable depth (any value >= 2,
//   not only powers of two). It provides occupancy-derived status flags and
//   sticky overflow/underflow error flags. In registered-read mode (FWFT=0),
//   read data appears one cycle after an accepted read. In first-word-fall-
//   through mode (FWFT=1), the head entry is always visible on dout.
//
// Parameters
//   DEPTH     number of entries (>= 2)
//   WIDTH     data width in bits
//   AF_LEVEL  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//   FWFT      0 = registered read, 1 = first-word-fall-through
//
// Ports
//   clk           rising-edge clock
//   rstn          asynchronous active-low reset
//   flush         synchronous clear of pointers, count and error flags
//   wr_en, din    write request and write data
//   rd_en         read request
//   dout          read data
//   dout_valid    dout carries valid data
//   full, empty, almost_full, almost_empty   status, decoded from count
//   count         current occupancy
//   overflow      sticky flag: a write was rejected
//   underflow     sticky flag: a read was rejected
//   clr_err       synchronous clear of overflow/underflow (wins over a set)
// -----------------------------------------------------------------------------
module stream_fifo #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  logic             rd_accept;
  logic             wr_accept;

  // Status flags come from the registered count only, so they have no
  // combinational path from any input.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A read is accepted only when data is present. A write may use the slot
  // freed by a read accepted in the same cycle. Flush suppresses both.
  assign rd_accept = rd_en && !empty && !flush;
  assign wr_accept = wr_en && (!full || rd_accept) && !flush;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      // Explicit wrap so non-power-of-two depths index correctly.
      if (wr_accept) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (rd_accept) begin
        rd_ptr_d     = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        dout_d       = mem_q[rd_ptr_q];
        dout_valid_d = 1'b1;
      end

      if (wr_accept && !rd_accept) begin
        count_d = count_q + CW'(1);
      end else if (rd_accept && !wr_accept) begin
        count_d = count_q - CW'(1);
      end

      // clr_err wins over a same-cycle set.
      if (clr_err) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end else begin
        if (wr_en && !wr_accept) overflow_d  = 1'b1;
        if (rd_en && !rd_accept) underflow_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so that every register
  // samples the pre-edge values, whatever order the simulator evaluates them in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // NOTE: the storage array has no reset. Resetting it would prevent mapping
  // to RAM, and the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // The head entry is shown directly. It reads as zero while empty, so
      // dout is defined after reset or flush.
      assign dout       = empty ? '0 : mem_q[rd_ptr_q];
      assign dout_valid = !empty;
    end else begin : g_reg
      assign dout       = dout_q;
      assign dout_valid = dout_valid_q;
    end
  endgenerate

endmodule
